// File: rtl/clk_gate_pkg.sv
// Shared definitions for the automatic clock-gating controller.
package clk_gate_pkg;

  typedef logic [1:0] cg_state_t;

  localparam logic [1:0] CG_OFF  = 2'd0;
  localparam logic [1:0] CG_WAKE = 2'd1;
  localparam logic [1:0] CG_ON   = 2'd2;
  localparam logic [1:0] CG_IDLE = 2'd3;

endpackage

// File: rtl/Standard_Cell_CLK_GATE.sv
// Behavioural model of the library integrated clock-gate cell (latch on low phase, AND).
module Standard_Cell_CLK_GATE (
  input  logic CK,
  input  logic EN,
  input  logic SE,
  output logic Q
);

  logic en_l;

  // Transparent while CK is low so Q can only change on a rising CK.
  always_latch begin
    if (!CK) en_l = EN | SE;
  end

  assign Q = CK & en_l;

endmodule

// File: rtl/clk_gate_chan_fsm.sv
// One channel's gating FSM: wakes on activity, closes the gate after a run of idle cycles.
module clk_gate_chan_fsm
  import clk_gate_pkg::*;
#(
  parameter int unsigned CW       = 8,
  parameter int unsigned WAKE_CYC = 2,
  parameter int unsigned RST_ON   = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          busy,
  input  logic          force_on,
  input  logic [CW-1:0] idle_thr,
  output logic          en,
  output logic          ack,
  output cg_state_t     state
);

  localparam cg_state_t   RST_STATE = (RST_ON != 0) ? CG_ON : CG_OFF;
  localparam logic        RST_OUT   = (RST_ON != 0);
  localparam logic [CW-1:0] WAKE_LAST = CW'(WAKE_CYC - 1);

  cg_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          en_q, en_d;
  logic          ack_q, ack_d;

  logic          act;
  logic [CW-1:0] thr_eff;
  logic [CW:0]   cnt_inc;
  logic [CW-1:0] cnt_sat;

  always_comb begin
    act     = req | busy | force_on;
    thr_eff = (idle_thr == '0) ? CW'(1) : idle_thr;
    cnt_inc = {1'b0, cnt_q} + (CW+1)'(1);
    cnt_sat = (cnt_q == '1) ? cnt_q : cnt_inc[CW-1:0];
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CG_OFF: begin
        if (act) begin
          state_d = CG_WAKE;
          cnt_d   = '0;
        end
      end
      CG_WAKE: begin
        if (cnt_q == WAKE_LAST) begin
          state_d = CG_ON;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_sat;
        end
      end
      CG_ON: begin
        if (act) begin
          cnt_d = '0;
        end else if (thr_eff == CW'(1)) begin
          state_d = CG_OFF;
          cnt_d   = '0;
        end else begin
          state_d = CG_IDLE;
          cnt_d   = CW'(1);
        end
      end
      CG_IDLE: begin
        if (act) begin
          state_d = CG_ON;
          cnt_d   = '0;
        end else if (cnt_inc >= {1'b0, thr_eff}) begin
          state_d = CG_OFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_sat;
        end
      end
      default: begin
        state_d = CG_OFF;
        cnt_d   = '0;
      end
    endcase
    en_d  = (state_d != CG_OFF);
    ack_d = (state_d == CG_ON) || (state_d == CG_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      en_q    <= RST_OUT;
      ack_q   <= RST_OUT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      ack_q   <= ack_d;
    end
  end

  assign en    = en_q;
  assign ack   = ack_q;
  assign state = state_q;

endmodule

// File: rtl/clk_gate_ctrl_nch.sv
// NCH-channel automatic clock-gating controller: one FSM and one ICG cell per channel.
module clk_gate_ctrl_nch
  import clk_gate_pkg::*;
#(
  parameter int unsigned NCH      = 4,
  parameter int unsigned CW       = 8,
  parameter int unsigned WAKE_CYC = 2,
  parameter int unsigned RST_ON   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scan_en,
  input  logic [NCH-1:0]   ch_req,
  input  logic [NCH-1:0]   ch_busy,
  input  logic [NCH-1:0]   cfg_force_on,
  input  logic [CW-1:0]    cfg_idle_thr,
  output logic [NCH-1:0]   gclk,
  output logic [NCH-1:0]   ch_en,
  output logic [NCH-1:0]   ch_ack,
  output logic [2*NCH-1:0] ch_state
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    cg_state_t st;

    clk_gate_chan_fsm #(
      .CW       (CW),
      .WAKE_CYC (WAKE_CYC),
      .RST_ON   (RST_ON)
    ) u_fsm (
      .clk      (clk),
      .rst      (rst),
      .req      (ch_req[i]),
      .busy     (ch_busy[i]),
      .force_on (cfg_force_on[i]),
      .idle_thr (cfg_idle_thr),
      .en       (ch_en[i]),
      .ack      (ch_ack[i]),
      .state    (st)
    );

    assign ch_state[2*i +: 2] = st;

    Standard_Cell_CLK_GATE u_icg (
      .CK (clk),
      .EN (ch_en[i]),
      .SE (scan_en),
      .Q  (gclk[i])
    );
  end

endmodule
